alu_mc: RTL and testbench

- Parametrised, registered, multi-cycle successor to the pipeline's combinational ALU.
- Keeps the existing 4-bit aluc encoding and zero flag, generalises datapath width, and adds set-less-than and an iterative multiply.
- Uses a valid/ready handshake on both sides so EX-stage control can stall on long operations.

---
 rtl/alu_mc_pkg.sv | 24 ++
 rtl/alu_mc_mul.sv | 79 +++++++
 rtl/alu_mc.sv | 144 ++++++++++++++
 tb/tb_alu_mc.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared opcode encodings and FSM state type for the multi-cycle ALU.
// Optional overflow output is enabled with ALU_MC_OVF_EN.
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_LUI  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1100;
    localparam logic [3:0] OP_MUL  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mc_mul.sv
// Iterative shift-add multiplier, one partial product per clock, WIDTH steps.
// With ALU_MC_OVF_EN the signed high half of the product is also produced.
module alu_mc_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod
`ifdef ALU_MC_OVF_EN
    ,
    output logic [WIDTH-1:0] prod_hi
`endif
);

    localparam int CW = $clog2(WIDTH);
`ifdef ALU_MC_OVF_EN
    localparam int PW = 2 * WIDTH;
`else
    localparam int PW = WIDTH;
`endif

    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_d;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;

    always_comb begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // The final step's sum is presented combinationally so the caller can
    // register it on the same edge that completes the WIDTH-th step.
    assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign prod = acc_d[WIDTH-1:0];

`ifdef ALU_MC_OVF_EN
    logic [WIDTH-1:0] corr_q;

    // Unsigned product minus the sign corrections gives the signed high half.
    assign prod_hi = acc_d[PW-1:WIDTH] - corr_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`ifdef ALU_MC_OVF_EN
            corr_q   <= '0;
`endif
        end else if (start) begin
            busy_q   <= 1'b1;
            acc_q    <= '0;
            mcand_q  <= PW'(a);
            mplier_q <= b;
            cnt_q    <= '0;
`ifdef ALU_MC_OVF_EN
            corr_q   <= (a[WIDTH-1] ? b : '0) + (b[WIDTH-1] ? a : '0);
`endif
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered multi-cycle ALU with valid/ready handshake on both sides.
// Define ALU_MC_OVF_EN to add the registered signed-overflow output ovf.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             z
`ifdef ALU_MC_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] s_q;
    logic             z_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    assign sum   = a + b;
    assign diff  = a - b;
    assign shamt = a[SHW-1:0];

    always_comb begin
        res_d = '0;
        case (aluc)
            OP_ADD:  res_d = sum;
            OP_SUB:  res_d = diff;
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_LUI:  res_d = b << (WIDTH / 2);
            OP_SLL:  res_d = b << shamt;
            OP_SRL:  res_d = b >> shamt;
            OP_SRA:  res_d = $unsigned($signed(b) >>> shamt);
            OP_SLT:  res_d = WIDTH'($signed(a) < $signed(b));
            OP_SLTU: res_d = WIDTH'(a < b);
            default: res_d = '0;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (aluc == OP_MUL);
    assign out_valid = (state_q == ST_DONE);
    assign s         = s_q;
    assign z         = z_q;

`ifdef ALU_MC_OVF_EN
    logic [WIDTH-1:0] mul_hi;
    logic             ovf_q;
    logic             ovf_d;
    logic             mul_ovf;

    always_comb begin
        ovf_d = 1'b0;
        case (aluc)
            OP_ADD:  ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default: ovf_d = 1'b0;
        endcase
    end

    // The product fits when the high half is pure sign extension of the low half.
    assign mul_ovf = (mul_hi != {WIDTH{mul_prod[WIDTH-1]}});
    assign ovf     = ovf_q;
`endif

    alu_mc_mul #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .prod    (mul_prod)
`ifdef ALU_MC_OVF_EN
        ,
        .prod_hi (mul_hi)
`endif
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            z_q     <= 1'b0;
`ifdef ALU_MC_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // DONE with out_ready behaves like IDLE, giving back-to-back accepts.
                    if (accept) begin
                        if (aluc == OP_MUL) begin
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_DONE;
                            s_q     <= res_d;
                            z_q     <= (res_d == '0);
`ifdef ALU_MC_OVF_EN
                            ovf_q   <= ovf_d;
`endif
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (mul_done) begin
                        state_q <= ST_DONE;
                        s_q     <= mul_prod;
                        z_q     <= (mul_prod == '0);
`ifdef ALU_MC_OVF_EN
                        ovf_q   <= mul_ovf;
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed vectors push expectations, a monitor pops them.
// Overflow checks are compiled in when ALU_MC_OVF_EN is defined.
module tb_alu_mc;

    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b0100;
    localparam logic [3:0] AND_ = 4'b0001;
    localparam logic [3:0] OR_  = 4'b0101;
    localparam logic [3:0] XOR_ = 4'b0010;
    localparam logic [3:0] LUI  = 4'b0110;
    localparam logic [3:0] SLL  = 4'b0011;
    localparam logic [3:0] SRL  = 4'b0111;
    localparam logic [3:0] SRA  = 4'b1111;
    localparam logic [3:0] SLT  = 4'b1000;
    localparam logic [3:0] SLTU = 4'b1100;
    localparam logic [3:0] MUL  = 4'b1001;

    typedef struct {
        logic [31:0] s;
        logic        z;
        logic        o;
        string       name;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  aluc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        z;
`ifdef ALU_MC_OVF_EN
    logic        ovf;
`endif

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   resultCount = 0;
    int   cycleCount = 0;

    alu_mc #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .aluc      (aluc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .z         (z)
`ifdef ALU_MC_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, expv);
        end
    endtask

    // Results are sampled on the falling edge ahead of the consuming rising edge.
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            resultCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got s=%h with no expectation queued", s);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput({e.name, "_s"}, s, e.s);
                checkOutput({e.name, "_z"}, 32'(z), 32'(e.z));
`ifdef ALU_MC_OVF_EN
                checkOutput({e.name, "_ovf"}, 32'(ovf), 32'(e.o));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] es, input logic eo, input bit push,
                                 input string nm, output int waited);
        bit   taken = 0;
        exp_t e;
        in_valid = 1'b1;
        aluc     = op;
        a        = av;
        b        = bv;
        waited   = 0;
        while (!taken && waited < 100) begin
            @(negedge clock);
            if (in_ready) taken = 1;
            @(posedge clock);
            #1;
            if (!taken) waited++;
        end
        in_valid = 1'b0;
        if (!taken) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_accept_timeout: got no accept expected accept within 100 cycles", nm);
        end else if (push) begin
            e.s = es;
            e.z = (es == 32'h0);
            e.o = eo;
            e.name = nm;
            expQ.push_back(e);
        end
    endtask

    initial begin
        int w;
        int n;
        int c0;
        int r0;
        bit sawBad;

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        aluc      = '0;
        out_ready = 1'b1;
        repeat (2) tick();
        reset = 1'b0;

        checkOutput("rst_s", s, 32'h0);
        checkOutput("rst_z", 32'(z), 32'h0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);

        applyStimulus(ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1, "add", w);
        checkOutput("add_latency", 32'(out_valid), 32'h1);
        applyStimulus(SUB, 32'd9, 32'd9, 32'd0, 1'b0, 1, "sub_zero", w);
        applyStimulus(SRA, 32'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 1, "sra", w);
        applyStimulus(SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, "slt", w);
        applyStimulus(SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, "sltu", w);
        applyStimulus(AND_, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1, "and", w);
        applyStimulus(OR_, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1, "or", w);
        applyStimulus(XOR_, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 1, "xor", w);
        applyStimulus(LUI, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1234_0000, 1'b0, 1, "lui", w);
        applyStimulus(SLL, 32'd36, 32'd1, 32'h0000_0010, 1'b0, 1, "sll_wrapamt", w);
        applyStimulus(SRL, 32'd8, 32'h8000_0000, 32'h0080_0000, 1'b0, 1, "srl", w);
        applyStimulus(ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1, "add_wrap", w);
        applyStimulus(SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1, "sub_wrap", w);
        applyStimulus(4'b1010, 32'd3, 32'd4, 32'd0, 1'b0, 1, "undef_op", w);
        checkOutput("undef_latency", 32'(out_valid), 32'h1);

        // MUL latency: in_ready must stay low and unrelated requests must be ignored.
        applyStimulus(MUL, 32'h0001_0000, 32'h0003_0001, 32'h0001_0000, 1'b1, 1, "mul", w);
        in_valid = 1'b1;
        aluc     = ADD;
        n        = 0;
        sawBad   = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) sawBad = 1;
            a = $urandom;
            b = $urandom;
            tick();
            n++;
        end
        in_valid = 1'b0;
        checkOutput("mul_latency", 32'(n), 32'd32);
        checkOutput("mul_busy_in_ready", 32'(sawBad), 32'h0);
        tick();

        // Backpressure: result must hold and nothing new may enter.
        out_ready = 1'b0;
        applyStimulus(ADD, 32'd3, 32'd4, 32'd7, 1'b0, 1, "hold_add", w);
        in_valid = 1'b1;
        aluc     = ADD;
        a        = 32'd10;
        b        = 32'd20;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_s", s, 32'd7);
            checkOutput("hold_ctl", 32'({out_valid, in_ready, z}), 32'b100);
            tick();
        end
        out_ready = 1'b1;
        applyStimulus(ADD, 32'd10, 32'd20, 32'd30, 1'b0, 1, "pulse_add", w);
        checkOutput("pulse_same_edge", 32'(w), 32'd0);
        checkOutput("pulse_s", s, 32'd30);

        // Reset mid-multiply must leave no result behind.
        applyStimulus(MUL, 32'd3, 32'd5, 32'd15, 1'b0, 0, "mul_abort", w);
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort_out_valid", 32'(out_valid), 32'h0);
        checkOutput("abort_s", s, 32'h0);
        checkOutput("abort_in_ready", 32'(in_ready), 32'h1);
        sawBad = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) sawBad = 1;
            tick();
        end
        checkOutput("abort_no_stale", 32'(sawBad), 32'h0);

        // Eight back-to-back single-cycle ops at one per cycle.
        c0 = cycleCount;
        r0 = resultCount;
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(ADD, 32'(i * 100), 32'(i), 32'(i * 101), 1'b0, 1, "stream", w);
        end
        checkOutput("stream_cycles", 32'(cycleCount - c0), 32'd8);
        tick();
        checkOutput("stream_results", 32'(resultCount - r0), 32'd8);

        applyStimulus(MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 1, "mul_neg", w);
        applyStimulus(MUL, 32'd7, 32'd6, 32'd42, 1'b0, 1, "mul_small", w);
`ifdef ALU_MC_OVF_EN
        applyStimulus(ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1, "add_ovf", w);
        applyStimulus(SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1, "sub_ovf", w);
        applyStimulus(MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1, "mul_ovf", w);
`endif

        n = 0;
        while (expQ.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
